// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue and hazard signals shared between the register-file writeback arbiter
// and its surroundings: the two writeback sources, decode, and the register file.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            issue_valid;
    logic            issue_long;
    logic [4:0]      issue_rd;
    logic [4:0]      chk_rs1;
    logic [4:0]      chk_rs2;
    logic            hazard_stall;
    logic            regwrite;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  issue_valid, issue_long, issue_rd, chk_rs1, chk_rs2,
        output a_ready, b_ready, hazard_stall, regwrite, rd, rd_data
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output issue_valid, issue_long, issue_rd, chk_rs1, chk_rs2,
        input  a_ready, b_ready, hazard_stall, regwrite, rd, rd_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source register-file writeback arbiter with a starvation-bounded priority, a pending-write
// scoreboard for long-latency results, and a registered commit stage. Optional: RFA_PERF_CNT_EN.
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned XLEN         = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
`ifdef RFA_PERF_CNT_EN
    ,
    output logic [31:0]         a_stall_cnt,
    output logic [31:0]         b_stall_cnt
`endif
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0]      wait_q, wait_d;
    logic [31:0]     pend_q, pend_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            commit_b_q, commit_b_d;

    logic prio_b, a_ready, b_ready, a_acc, b_acc;
    logic rs1_haz, rs2_haz, waw_haz, hazard, issue_set;

    always_comb begin
        prio_b = (wait_q == Limit);
        if (prio_b) begin
            b_ready = bus.b_valid;
            a_ready = ~bus.b_valid;
        end else begin
            a_ready = 1'b1;
            b_ready = bus.b_valid & ~bus.a_valid;
        end
        a_acc = bus.a_valid & a_ready;
        b_acc = bus.b_valid & b_ready;
    end

    // A B result leaving the scoreboard is still one edge away from the register file.
    always_comb begin
        rs1_haz = (bus.chk_rs1 != 5'd0) &
                  (pend_q[bus.chk_rs1] | (commit_b_q & (rd_q == bus.chk_rs1)));
        rs2_haz = (bus.chk_rs2 != 5'd0) &
                  (pend_q[bus.chk_rs2] | (commit_b_q & (rd_q == bus.chk_rs2)));
        waw_haz = bus.issue_long & pend_q[bus.issue_rd];
        hazard  = rs1_haz | rs2_haz | waw_haz;
        issue_set = bus.issue_valid & bus.issue_long & ~hazard & (bus.issue_rd != 5'd0);
    end

    always_comb begin
        if (!bus.b_valid || b_ready) begin
            wait_d = 4'd0;
        end else if (wait_q != Limit) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    // Set is applied after clear so a same-edge reissue of the register keeps it pending.
    always_comb begin
        pend_d = pend_q;
        if (b_acc) begin
            pend_d[bus.b_rd] = 1'b0;
        end
        if (issue_set) begin
            pend_d[bus.issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        regwrite_d = 1'b0;
        commit_b_d = 1'b0;
        rd_d       = rd_q;
        data_d     = data_q;
        if (b_acc) begin
            regwrite_d = (bus.b_rd != 5'd0);
            commit_b_d = 1'b1;
            rd_d       = bus.b_rd;
            data_d     = bus.b_data;
        end else if (a_acc) begin
            regwrite_d = (bus.a_rd != 5'd0);
            rd_d       = bus.a_rd;
            data_d     = bus.a_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q     <= 4'd0;
            pend_q     <= 32'd0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            data_q     <= '0;
            commit_b_q <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            pend_q     <= pend_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            commit_b_q <= commit_b_d;
        end
    end

    assign bus.a_ready      = a_ready;
    assign bus.b_ready      = b_ready;
    assign bus.hazard_stall = hazard;
    assign bus.regwrite     = regwrite_q;
    assign bus.rd           = rd_q;
    assign bus.rd_data      = data_q;

`ifdef RFA_PERF_CNT_EN
    logic [31:0] a_cnt_q, b_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= 32'd0;
            b_cnt_q <= 32'd0;
        end else begin
            if (bus.a_valid && !a_ready) a_cnt_q <= a_cnt_q + 32'd1;
            if (bus.b_valid && !b_ready) b_cnt_q <= b_cnt_q + 32'd1;
        end
    end

    assign a_stall_cnt = a_cnt_q;
    assign b_stall_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration, scoreboard and commit rules.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_wb_arbiter_if #(.XLEN(32)) bus ();

`ifdef RFA_PERF_CNT_EN
    logic [31:0] a_stall_cnt, b_stall_cnt;
    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .a_stall_cnt(a_stall_cnt),
        .b_stall_cnt(b_stall_cnt)
    );
`else
    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a set of owed registers, B's waiting time, and the last commit.
    bit          m_pend[32];
    int          m_wait;
    bit          m_rw;
    int          m_rd;
    logic [31:0] m_data;
    int          m_inflight;  // register of a B commit still in flight, 0 when none

    function automatic bit f_a_ready();
        return (m_wait >= LIMIT) ? !bus.b_valid : 1'b1;
    endfunction

    function automatic bit f_b_ready();
        return (m_wait >= LIMIT) ? bus.b_valid : (bus.b_valid && !bus.a_valid);
    endfunction

    function automatic bit f_src_haz(int rs);
        return (rs != 0) && (m_pend[rs] || (m_inflight == rs));
    endfunction

    function automatic bit f_hazard();
        return f_src_haz(int'(bus.chk_rs1)) || f_src_haz(int'(bus.chk_rs2)) ||
               (bus.issue_long && m_pend[bus.issue_rd]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_wait = 0; m_rw = 1'b0; m_rd = 0; m_data = 32'd0; m_inflight = 0;
    endtask

    task automatic model_step();
        bit aa, ba, hz;
        int nwait;
        aa = bus.a_valid && f_a_ready();
        ba = bus.b_valid && f_b_ready();
        hz = f_hazard();
        nwait = (bus.b_valid && !ba) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
        if (ba) begin
            m_rw = (bus.b_rd != 0); m_rd = int'(bus.b_rd); m_data = bus.b_data;
            m_inflight = int'(bus.b_rd);
            m_pend[bus.b_rd] = 1'b0;
        end else if (aa) begin
            m_rw = (bus.a_rd != 0); m_rd = int'(bus.a_rd); m_data = bus.a_data;
            m_inflight = 0;
        end else begin
            m_rw = 1'b0; m_inflight = 0;
        end
        if (bus.issue_valid && bus.issue_long && !hz && bus.issue_rd != 0)
            m_pend[bus.issue_rd] = 1'b1;
        m_wait = nwait;
    endtask

    task automatic drive_idle();
        bus.a_valid = 1'b0; bus.a_rd = 5'd0; bus.a_data = 32'd0;
        bus.b_valid = 1'b0; bus.b_rd = 5'd0; bus.b_data = 32'd0;
        bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.issue_rd = 5'd0;
        bus.chk_rs1 = 5'd0; bus.chk_rs2 = 5'd0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        settle();
        n_checks++;
        if (bus.regwrite !== 1'b0 || bus.rd !== 5'd0 || bus.rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rw=%0b rd=%0d data=%h, expected 0/0/0",
                     bus.regwrite, bus.rd, bus.rd_data);
        end
        n_checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0 || bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_comb: got a_rdy=%0b b_rdy=%0b stall=%0b, expected 1/0/0",
                     bus.a_ready, bus.b_ready, bus.hazard_stall);
        end
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hAAAA;
        tick();
        n_checks++;
        if (bus.regwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_precommit: got regwrite=%0b expected 1", bus.regwrite);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.regwrite !== 1'b0 || bus.rd !== 5'd0 || bus.rd_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_async: got rw=%0b rd=%0d data=%h, expected 0/0/0",
                     bus.regwrite, bus.rd, bus.rd_data);
        end
        @(posedge clk);
        #3 bus.a_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        settle();
        n_checks++;
        if (bus.regwrite !== 1'b0 || bus.rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_no_commit: got rw=%0b rd=%0d expected 0/0",
                     bus.regwrite, bus.rd);
        end
    endtask

    task automatic test_a_only();
        drive_idle();
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h1234;
        settle();
        n_checks++;
        if (bus.a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL a_only_ready: got %0b expected 1", bus.a_ready);
        end
        tick();
        bus.a_rd = 5'd0; bus.a_data = 32'h5555;
        settle();
        n_checks++;
        if (bus.regwrite !== 1'b1 || bus.rd !== 5'd5 || bus.rd_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL a_only_commit: got rw=%0b rd=%0d data=%h expected 1/5/1234",
                     bus.regwrite, bus.rd, bus.rd_data);
        end
        tick();
        bus.a_valid = 1'b0;
        settle();
        n_checks++;
        if (bus.regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL a_only_x0: got regwrite=%0b expected 0", bus.regwrite);
        end
        tick();
    endtask

    task automatic test_contention();
        drive_idle();
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'h1111;
        bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'hBEEF;
        for (int i = 0; i < LIMIT; i++) begin
            settle();
            n_checks++;
            if (bus.b_ready !== 1'b0 || bus.a_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL contention_wait%0d: got b_rdy=%0b a_rdy=%0b expected 0/1",
                         i, bus.b_ready, bus.a_ready);
            end
            tick();
        end
        settle();
        n_checks++;
        if (bus.b_ready !== 1'b1 || bus.a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_grant: got b_rdy=%0b a_rdy=%0b expected 1/0",
                     bus.b_ready, bus.a_ready);
        end
        tick();
        bus.b_data = 32'hCAFE;
        settle();
        n_checks++;
        if (bus.regwrite !== 1'b1 || bus.rd !== 5'd7 || bus.rd_data !== 32'hBEEF) begin
            n_fail++;
            $display("FAIL contention_commit: got rw=%0b rd=%0d data=%h expected 1/7/beef",
                     bus.regwrite, bus.rd, bus.rd_data);
        end
        n_checks++;
        if (bus.b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_cnt_clear: got b_ready=%0b expected 0", bus.b_ready);
        end
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_raw();
        drive_idle();
        bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd9;
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_issue: got stall=%0b expected 0", bus.hazard_stall);
        end
        tick();
        bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.chk_rs1 = 5'd9;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if (bus.hazard_stall !== 1'b1) begin
                n_fail++;
                $display("FAIL raw_pending%0d: got stall=%0b expected 1", i, bus.hazard_stall);
            end
            tick();
        end
        bus.b_valid = 1'b1; bus.b_rd = 5'd9; bus.b_data = 32'h99;
        settle();
        n_checks++;
        if (bus.b_ready !== 1'b1 || bus.hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_accept: got b_rdy=%0b stall=%0b expected 1/1",
                     bus.b_ready, bus.hazard_stall);
        end
        tick();
        bus.b_valid = 1'b0;
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_inflight: got stall=%0b expected 1", bus.hazard_stall);
        end
        tick();
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_release: got stall=%0b expected 0", bus.hazard_stall);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_waw_x0();
        drive_idle();
        bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd3;
        tick();
        bus.issue_valid = 1'b0;
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_stall: got stall=%0b expected 1", bus.hazard_stall);
        end
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_issue: got stall=%0b expected 0", bus.hazard_stall);
        end
        tick();
        bus.issue_valid = 1'b0; bus.issue_long = 1'b0; bus.chk_rs1 = 5'd0;
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_check: got stall=%0b expected 0", bus.hazard_stall);
        end
        bus.chk_rs2 = 5'd3;
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_rs2: got stall=%0b expected 1", bus.hazard_stall);
        end
        drive_idle();
        bus.b_valid = 1'b1; bus.b_rd = 5'd3; bus.b_data = 32'h33;
        tick();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_same_edge();
        drive_idle();
        bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'h44;
        bus.issue_valid = 1'b1; bus.issue_long = 1'b1; bus.issue_rd = 5'd4;
        settle();
        n_checks++;
        if (bus.b_ready !== 1'b1 || bus.hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL same_edge_setup: got b_rdy=%0b stall=%0b expected 1/0",
                     bus.b_ready, bus.hazard_stall);
        end
        tick();
        drive_idle();
        bus.chk_rs1 = 5'd4;
        tick();
        tick();
        settle();
        n_checks++;
        if (bus.hazard_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL same_edge_pending: got stall=%0b expected 1", bus.hazard_stall);
        end
        drive_idle();
        bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'h45;
        tick();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_random();
        bit b_hold = 1'b0;
        drive_idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!b_hold) begin
                bus.b_valid = ($urandom % 3) == 0;
                bus.b_rd    = 5'($urandom_range(0, 7));
                bus.b_data  = $urandom;
            end
            bus.a_valid     = ($urandom % 2) == 0;
            bus.a_rd        = 5'($urandom_range(0, 31));
            bus.a_data      = $urandom;
            bus.issue_valid = ($urandom % 3) == 0;
            bus.issue_long  = ($urandom % 2) == 0;
            bus.issue_rd    = 5'($urandom_range(0, 7));
            bus.chk_rs1     = 5'($urandom_range(0, 7));
            bus.chk_rs2     = 5'($urandom_range(0, 7));
            settle();
            n_checks++;
            if (bus.a_ready !== f_a_ready() || bus.b_ready !== f_b_ready()) begin
                n_fail++;
                $display("FAIL rand_ready cyc%0d: got a=%0b b=%0b expected a=%0b b=%0b",
                         cyc, bus.a_ready, bus.b_ready, f_a_ready(), f_b_ready());
            end
            n_checks++;
            if (bus.hazard_stall !== f_hazard()) begin
                n_fail++;
                $display("FAIL rand_hazard cyc%0d: got %0b expected %0b",
                         cyc, bus.hazard_stall, f_hazard());
            end
            n_checks++;
            if (bus.regwrite !== m_rw || bus.rd !== 5'(m_rd) || bus.rd_data !== m_data) begin
                n_fail++;
                $display("FAIL rand_commit cyc%0d: got rw=%0b rd=%0d data=%h expected %0b/%0d/%h",
                         cyc, bus.regwrite, bus.rd, bus.rd_data, m_rw, m_rd, m_data);
            end
            b_hold = bus.b_valid && !f_b_ready();
            tick();
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_raw();
        test_waw_x0();
        test_same_edge();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 integer register file between two writeback sources.
  - Source A: the in-order pipeline writeback.
  - Source B: the long-latency unit (load/multiply).
- Keeps a pending-write scoreboard of destination registers owed by source B.
- Raises a stall to the decode stage on RAW/WAW hazards against those registers.
- Drives the register file's regwrite/rd/rd_data from a registered commit stage.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles source B may wait before it takes priority over source A (1..15).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a_valid  input  1  source A has a write.
- a_ready  output  1  source A write accepted this cycle.
- a_rd  input  5  source A destination.
- a_data  input  XLEN  source A data.
- b_valid  input  1  source B has a write; held with rd/data until b_ready.
- b_ready  output  1  source B write accepted this cycle.
- b_rd  input  5  source B destination.
- b_data  input  XLEN  source B data.
- issue_valid  input  1  decode issues an instruction this cycle.
- issue_long  input  1  issued instruction completes via source B.
- issue_rd  input  5  issued destination.
- chk_rs1  input  5  decode source register 1.
- chk_rs2  input  5  decode source register 2.
- hazard_stall  output  1  decode must not issue.
- regwrite  output  1  register file write enable.
- rd  output  5  register file write address.
- rd_data  output  XLEN  register file write data.

Behaviour:
- Reset (async, rst_n=0):
  - regwrite=0, rd=0, rd_data=0.
  - All pending bits clear; wait counter 0; prio_b=0.
  - a_ready/b_ready/hazard_stall evaluate combinationally from cleared state.
  - A reset asserted mid-operation discards any in-flight commit.
- Arbitration, combinational in the same cycle:
  - prio_b=0:
    - a_ready=1 always.
    - b_ready = b_valid & ~a_valid.
  - prio_b=1:
    - b_ready = b_valid.
    - a_ready = ~b_valid.
  - At most one of a_ready&a_valid, b_ready&b_valid is true.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle b_valid & ~b_ready.
  - Clears on any B acceptance or when b_valid=0.
  - prio_b = (counter == STARVE_LIMIT).
- Commit stage, one cycle latency:
  - On an accepted write, the next edge loads rd/rd_data from the winner.
  - regwrite=1 if winner rd != 0, else regwrite=0.
  - With no acceptance, regwrite=0 next cycle; rd/rd_data hold their values.
- Scoreboard (pending[31:1]; x0 never pending):
  - Set: issue_valid & issue_long & ~hazard_stall & issue_rd!=0 sets pending[issue_rd] at the edge.
  - Clear: pending[b_rd] clears at the edge B is accepted. The register file commits one edge later, so hazard also covers that cycle.
  - Simultaneous set and clear of the same index: set wins.
- hazard_stall, combinational, asserted if any of:
  - (pending[chk_rs1] or commit-stage B write in flight to chk_rs1), for chk_rs1 != 0.
  - The same condition for chk_rs2.
  - issue_long & pending[issue_rd] (WAW).
  - hazard_stall is advisory: decode gates issue_valid with it.
- Source A writing a register pending from B is not checked here; the decode stall prevents it.

Optional Feature:
- Macro RFA_PERF_CNT_EN.
- Defined:
  - Adds output a_stall_cnt [31:0], reset 0.
  - Increments, wrapping, each cycle a_valid & ~a_ready.
  - Adds output b_stall_cnt [31:0] with the same rule for source B.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 asynchronously mid-cycle with a_valid=1.
  - Response: regwrite=0, rd=0, rd_data=0 immediately; no commit after release until a new acceptance.
- A only:
  - Stimulus: a_valid=1, a_rd=5, a_data=0x1234.
  - Response: next cycle regwrite=1, rd=5, rd_data=0x1234.
  - Stimulus: a_rd=0.
  - Response: regwrite=0.
- Contention:
  - Stimulus: a_valid=1 every cycle, b_valid=1 b_rd=7 b_data=0xBEEF, STARVE_LIMIT=4.
  - Response: b_ready=0 for 4 cycles; cycle 5 b_ready=1 and a_ready=0; next cycle rd=7, rd_data=0xBEEF; counter back to 0.
- RAW:
  - Stimulus: issue long rd=9, then chk_rs1=9.
  - Response: hazard_stall=1 until B accepted with b_rd=9 plus one commit cycle; 0 thereafter.
- WAW and x0:
  - Stimulus: pending[3]=1, then issue_long issue_rd=3.
  - Response: hazard_stall=1.
  - Stimulus: issue_long issue_rd=0, then chk_rs1=0.
  - Response: hazard_stall=0.
- Same-edge set/clear:
  - Stimulus: B accepted with b_rd=4 in the same cycle a new long issue has issue_rd=4.
  - Response: pending[4] remains 1.
